ppu_fb_writer: RTL and testbench

// Consumes the PPU pixel stream (2-bit shade + valid) and writes it to a double-buffered framebuffer RAM.

---
 rtl/ppu_fb_writer_if.sv | 25 ++
 rtl/ppu_fb_writer.sv | 147 ++++++++++++++
 tb/tb_ppu_fb_writer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/ppu_fb_writer_if.sv
// Bundles the PPU pixel stream and the framebuffer write port of ppu_fb_writer.
// The master side feeds pixels and observes writes; the slave side is the writer.
interface ppu_fb_writer_if #(
  parameter int unsigned ADDR_W = 14
);
  logic [1:0]        PPU_MODE;
  logic [1:0]        PX_OUT;
  logic              PX_valid;
  logic              FB_WE;
  logic [ADDR_W-1:0] FB_ADDR;
  logic [7:0]        FB_WDATA;
  logic              FRONT_BUF;
  logic              FRAME_DONE;
  logic              FRAME_ERR;

  modport master (
    output PPU_MODE, PX_OUT, PX_valid,
    input  FB_WE, FB_ADDR, FB_WDATA, FRONT_BUF, FRAME_DONE, FRAME_ERR
  );

  modport slave (
    input  PPU_MODE, PX_OUT, PX_valid,
    output FB_WE, FB_ADDR, FB_WDATA, FRONT_BUF, FRAME_DONE, FRAME_ERR
  );
endinterface

// File: rtl/ppu_fb_writer.sv
// Packs the 2-bit PPU pixel stream four-per-byte into the back half of a
// double-buffered framebuffer and flips the front buffer after each full frame.
module ppu_fb_writer #(
  parameter int unsigned H_PIX  = 160,
  parameter int unsigned V_PIX  = 144,
  parameter int unsigned ADDR_W = 14
) (
  input  logic           clk,
  input  logic           rst,
  ppu_fb_writer_if.slave bus
);

  localparam int unsigned IDX_W = ADDR_W - 1;
  localparam int unsigned X_W   = $clog2(H_PIX);
  localparam int unsigned Y_W   = $clog2(V_PIX);
  localparam logic [1:0]  MODE_VBLANK = 2'd1;

  typedef enum logic [1:0] {
    SYNC,
    ACTIVE,
    DONE
  } state_t;

  state_t             state_q, state_n;
  logic [1:0]         mode_d;
  logic [1:0]         px_cnt_q, px_cnt_n;
  logic [X_W-1:0]     x_q, x_n;
  logic [Y_W-1:0]     y_q, y_n;
  logic [IDX_W-1:0]   byte_idx_q, byte_idx_n;
  logic [5:0]         pack_q, pack_n;
  logic               front_q, front_n;
  logic               we_q, we_n;
  logic [ADDR_W-1:0]  addr_q, addr_n;
  logic [7:0]         wdata_q, wdata_n;
  logic               done_q, done_n;
  logic               err_q, err_n;
  logic               vb_exit;

  // Leaving V-blank marks the start of a fresh frame.
  assign vb_exit = (mode_d == MODE_VBLANK) && (bus.PPU_MODE != MODE_VBLANK);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= SYNC;
      mode_d     <= 2'd0;
      px_cnt_q   <= 2'd0;
      x_q        <= '0;
      y_q        <= '0;
      byte_idx_q <= '0;
      pack_q     <= 6'd0;
      front_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 8'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_n;
      mode_d     <= bus.PPU_MODE;
      px_cnt_q   <= px_cnt_n;
      x_q        <= x_n;
      y_q        <= y_n;
      byte_idx_q <= byte_idx_n;
      pack_q     <= pack_n;
      front_q    <= front_n;
      we_q       <= we_n;
      addr_q     <= addr_n;
      wdata_q    <= wdata_n;
      done_q     <= done_n;
      err_q      <= err_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    px_cnt_n   = px_cnt_q;
    x_n        = x_q;
    y_n        = y_q;
    byte_idx_n = byte_idx_q;
    pack_n     = pack_q;
    front_n    = front_q;
    we_n       = 1'b0;
    addr_n     = addr_q;
    wdata_n    = wdata_q;
    done_n     = 1'b0;
    err_n      = 1'b0;

    case (state_q)
      SYNC: begin
        if (vb_exit) begin
          state_n    = ACTIVE;
          px_cnt_n   = 2'd0;
          x_n        = '0;
          y_n        = '0;
          byte_idx_n = '0;
          pack_n     = 6'd0;
        end
      end

      ACTIVE: begin
        // V-blank before the last pixel aborts the frame; a pixel in the same cycle is dropped.
        if (bus.PPU_MODE == MODE_VBLANK) begin
          err_n   = 1'b1;
          state_n = SYNC;
        end else if (bus.PX_valid) begin
          pack_n   = {pack_q[3:0], bus.PX_OUT};
          px_cnt_n = px_cnt_q + 2'd1;
          if (px_cnt_q == 2'd3) begin
            we_n       = 1'b1;
            addr_n     = {~front_q, byte_idx_q};
            wdata_n    = {pack_q, bus.PX_OUT};
            byte_idx_n = byte_idx_q + 1'b1;
          end
          if (x_q == X_W'(H_PIX - 1)) begin
            x_n = '0;
            if (y_q == Y_W'(V_PIX - 1)) begin
              y_n     = '0;
              done_n  = 1'b1;
              front_n = ~front_q;
              state_n = DONE;
            end else begin
              y_n = y_q + 1'b1;
            end
          end else begin
            x_n = x_q + 1'b1;
          end
        end
      end

      DONE: begin
        if (bus.PPU_MODE == MODE_VBLANK) begin
          state_n = SYNC;
        end
      end

      default: state_n = SYNC;
    endcase
  end

  assign bus.FB_WE      = we_q;
  assign bus.FB_ADDR    = addr_q;
  assign bus.FB_WDATA   = wdata_q;
  assign bus.FRONT_BUF  = front_q;
  assign bus.FRAME_DONE = done_q;
  assign bus.FRAME_ERR  = err_q;

endmodule

// File: tb/tb_ppu_fb_writer.sv
// Directed bench for ppu_fb_writer: frame commit, abort, pre-sync, trailing pixels, async reset.
`timescale 1ns/1ps
module tb_ppu_fb_writer;

  localparam int unsigned LINE_PX  = 160;
  localparam int unsigned FRAME_PX = 160 * 144;
  localparam int unsigned FRAME_B  = 5760;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   first_px_cyc = 0;

  ppu_fb_writer_if #(.ADDR_W(14)) bus ();

  ppu_fb_writer #(.H_PIX(160), .V_PIX(144), .ADDR_W(14)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write/pulse monitor, sampled on the falling edge.
  logic [13:0] addr_q[$];
  logic [7:0]  data_q[$];
  int          wcyc_q[$];
  int          done_cnt = 0;
  int          err_cnt = 0;
  logic        done_we = 1'b0;
  logic [13:0] done_addr = '0;

  always @(negedge clk) begin
    if (rst) begin
      if (bus.FB_WE) begin
        addr_q.push_back(bus.FB_ADDR);
        data_q.push_back(bus.FB_WDATA);
        wcyc_q.push_back(cyc);
      end
      if (bus.FRAME_DONE) begin
        done_cnt++;
        done_we   = bus.FB_WE;
        done_addr = bus.FB_ADDR;
      end
      if (bus.FRAME_ERR) err_cnt++;
    end
  end

  task automatic clear_mon();
    addr_q.delete();
    data_q.delete();
    wcyc_q.delete();
    done_cnt  = 0;
    err_cnt   = 0;
    done_we   = 1'b0;
    done_addr = '0;
  endtask

  task automatic vblank_exit();
    @(negedge clk);
    bus.PX_valid = 1'b0;
    bus.PPU_MODE = 2'd1;
    repeat (3) @(negedge clk);
    bus.PPU_MODE = 2'd2;
  endtask

  // sel 0: shade = x[1:0]; otherwise shade = 3.
  task automatic drive_pixels(input int n, input int sel);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) first_px_cyc = cyc;
      bus.PX_valid = 1'b1;
      bus.PX_OUT   = (sel == 0) ? 2'(i % 4) : 2'd3;
    end
    @(negedge clk);
    bus.PX_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.PPU_MODE = 2'd0;
    bus.PX_OUT   = 2'd0;
    bus.PX_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.FB_WE !== 1'b0) begin failures++; $display("FAIL reset_we got=%0b exp=0", bus.FB_WE); end
    checks++; if (bus.FB_ADDR !== 14'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", bus.FB_ADDR); end
    checks++; if (bus.FB_WDATA !== 8'd0) begin failures++; $display("FAIL reset_wdata got=%0h exp=0", bus.FB_WDATA); end
    checks++; if (bus.FRONT_BUF !== 1'b0) begin failures++; $display("FAIL reset_front got=%0b exp=0", bus.FRONT_BUF); end
    checks++; if (bus.FRAME_DONE !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", bus.FRAME_DONE); end
    checks++; if (bus.FRAME_ERR !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", bus.FRAME_ERR); end
    rst = 1'b1;
  endtask

  // Reset lands just after the byte write of pixel 80 on line 50.
  task automatic test_async_reset();
    vblank_exit();
    drive_pixels(50 * LINE_PX + 80, 0);
    #2;
    checks++; if (bus.FB_WE !== 1'b1) begin failures++; $display("FAIL midline_we got=%0b exp=1", bus.FB_WE); end
    checks++; if (bus.FB_ADDR !== 14'd10211) begin failures++; $display("FAIL midline_addr got=%0d exp=10211", bus.FB_ADDR); end
    rst = 1'b0;
    #1;
    checks++; if (bus.FB_WE !== 1'b0) begin failures++; $display("FAIL async_we got=%0b exp=0", bus.FB_WE); end
    checks++; if (bus.FB_ADDR !== 14'd0) begin failures++; $display("FAIL async_addr got=%0d exp=0", bus.FB_ADDR); end
    checks++; if (bus.FB_WDATA !== 8'd0) begin failures++; $display("FAIL async_wdata got=%0h exp=0", bus.FB_WDATA); end
    checks++; if (bus.FRONT_BUF !== 1'b0) begin failures++; $display("FAIL async_front got=%0b exp=0", bus.FRONT_BUF); end
    checks++; if (bus.FRAME_DONE !== 1'b0) begin failures++; $display("FAIL async_done got=%0b exp=0", bus.FRAME_DONE); end
    checks++; if (bus.FRAME_ERR !== 1'b0) begin failures++; $display("FAIL async_err got=%0b exp=0", bus.FRAME_ERR); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Pixels before the first V-blank exit are ignored; then a full x[1:0] frame to buffer 1.
  task automatic test_pre_sync_full_frame();
    int bad_a, bad_d, bad_c;
    clear_mon();
    bus.PPU_MODE = 2'd2;
    drive_pixels(16, 0);
    repeat (3) @(negedge clk);
    checks++; if (addr_q.size() != 0) begin failures++; $display("FAIL presync_writes got=%0d exp=0", addr_q.size()); end
    checks++; if (bus.FRONT_BUF !== 1'b0) begin failures++; $display("FAIL frame1_front_before got=%0b exp=0", bus.FRONT_BUF); end
    vblank_exit();
    drive_pixels(FRAME_PX, 0);
    repeat (3) @(negedge clk);
    checks++; if (addr_q.size() != FRAME_B) begin failures++; $display("FAIL frame1_count got=%0d exp=%0d", addr_q.size(), FRAME_B); end
    checks++; if (addr_q.size() == 0 || addr_q[0] !== 14'd8192) begin failures++; $display("FAIL frame1_first_addr got=%0d exp=8192", (addr_q.size() == 0) ? -1 : int'(addr_q[0])); end
    bad_a = -1; bad_d = -1; bad_c = -1;
    for (int i = 0; i < addr_q.size(); i++) begin
      if (bad_a < 0 && addr_q[i] !== 14'(8192 + i)) bad_a = i;
      if (bad_d < 0 && data_q[i] !== 8'h1B) bad_d = i;
      if (bad_c < 0 && wcyc_q[i] != first_px_cyc + 4 + 4 * i) bad_c = i;
    end
    checks++; if (bad_a >= 0) begin failures++; $display("FAIL frame1_addr idx=%0d got=%0d exp=%0d", bad_a, addr_q[bad_a], 8192 + bad_a); end
    checks++; if (bad_d >= 0) begin failures++; $display("FAIL frame1_data idx=%0d got=%0h exp=1b", bad_d, data_q[bad_d]); end
    checks++; if (bad_c >= 0) begin failures++; $display("FAIL frame1_timing idx=%0d got=%0d exp=%0d", bad_c, wcyc_q[bad_c], first_px_cyc + 4 + 4 * bad_c); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL frame1_done got=%0d exp=1", done_cnt); end
    checks++; if (done_we !== 1'b1 || done_addr !== 14'd13951) begin failures++; $display("FAIL frame1_done_write got_we=%0b got_addr=%0d exp_we=1 exp_addr=13951", done_we, done_addr); end
    checks++; if (err_cnt != 0) begin failures++; $display("FAIL frame1_err got=%0d exp=0", err_cnt); end
    checks++; if (bus.FRONT_BUF !== 1'b1) begin failures++; $display("FAIL frame1_front got=%0b exp=1", bus.FRONT_BUF); end
  endtask

  task automatic test_extra_pixels();
    clear_mon();
    drive_pixels(8, 1);
    repeat (3) @(negedge clk);
    checks++; if (addr_q.size() != 0) begin failures++; $display("FAIL extra_writes got=%0d exp=0", addr_q.size()); end
    checks++; if (err_cnt != 0) begin failures++; $display("FAIL extra_err got=%0d exp=0", err_cnt); end
    checks++; if (bus.FRONT_BUF !== 1'b1) begin failures++; $display("FAIL extra_front got=%0b exp=1", bus.FRONT_BUF); end
  endtask

  // V-blank after 100 lines, with a pixel in the same cycle.
  task automatic test_short_frame();
    vblank_exit();
    clear_mon();
    drive_pixels(100 * LINE_PX, 1);
    bus.PX_valid = 1'b1;
    bus.PX_OUT   = 2'd3;
    bus.PPU_MODE = 2'd1;
    @(negedge clk);
    bus.PX_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (addr_q.size() != 4000) begin failures++; $display("FAIL short_count got=%0d exp=4000", addr_q.size()); end
    checks++; if (addr_q.size() == 0 || addr_q[addr_q.size() - 1] !== 14'd3999) begin failures++; $display("FAIL short_last_addr got=%0d exp=3999", (addr_q.size() == 0) ? -1 : int'(addr_q[addr_q.size() - 1])); end
    checks++; if (err_cnt != 1) begin failures++; $display("FAIL short_err got=%0d exp=1", err_cnt); end
    checks++; if (done_cnt != 0) begin failures++; $display("FAIL short_done got=%0d exp=0", done_cnt); end
    checks++; if (bus.FRONT_BUF !== 1'b1) begin failures++; $display("FAIL short_front got=%0b exp=1", bus.FRONT_BUF); end
  endtask

  // Full all-3 frame after the abort: restarts at byte 0 of buffer 0.
  task automatic test_second_frame();
    int bad_a, bad_d;
    clear_mon();
    vblank_exit();
    drive_pixels(FRAME_PX, 1);
    repeat (3) @(negedge clk);
    checks++; if (addr_q.size() != FRAME_B) begin failures++; $display("FAIL frame2_count got=%0d exp=%0d", addr_q.size(), FRAME_B); end
    checks++; if (addr_q.size() == 0 || addr_q[0] !== 14'd0) begin failures++; $display("FAIL frame2_first_addr got=%0d exp=0", (addr_q.size() == 0) ? -1 : int'(addr_q[0])); end
    bad_a = -1; bad_d = -1;
    for (int i = 0; i < addr_q.size(); i++) begin
      if (bad_a < 0 && addr_q[i] !== 14'(i)) bad_a = i;
      if (bad_d < 0 && data_q[i] !== 8'hFF) bad_d = i;
    end
    checks++; if (bad_a >= 0) begin failures++; $display("FAIL frame2_addr idx=%0d got=%0d exp=%0d", bad_a, addr_q[bad_a], bad_a); end
    checks++; if (bad_d >= 0) begin failures++; $display("FAIL frame2_data idx=%0d got=%0h exp=ff", bad_d, data_q[bad_d]); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL frame2_done got=%0d exp=1", done_cnt); end
    checks++; if (bus.FRONT_BUF !== 1'b0) begin failures++; $display("FAIL frame2_front got=%0b exp=0", bus.FRONT_BUF); end
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_pre_sync_full_frame();
    test_extra_pixels();
    test_short_frame();
    test_second_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
